// File: rtl/serial_tx_arb_pkg.sv
// serial_tx_arb shared constants: flit geometry
// and transmitter state encodings.
package serial_tx_arb_pkg;

  localparam int HDR_SZ  = 4;
  localparam int PL_SZ   = 8;
  localparam int ADDR_SZ = 4;
  localparam int FLIT_W_DEF = HDR_SZ + PL_SZ + ADDR_SZ;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_SHIFT = 2'd2,
    TX_GUARD = 2'd3
  } tx_state_e;

endpackage

// File: rtl/serial_tx_arb_if.sv
// Requester/channel bundle for serial_tx_arb.
// The master side drives requests and channel_busy.
interface serial_tx_arb_if
  import serial_tx_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int IDW    = 2
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ*FLIT_W-1:0] req_data;
  logic [NREQ-1:0]        req_ready;
  logic                   channel_busy;
  logic                   serial_out;
  logic [IDW-1:0]         grant_id;
  logic                   tx_active;

  modport master (
    output req_valid, req_data, channel_busy,
    input  req_ready, serial_out, grant_id, tx_active
  );

  modport slave (
    input  req_valid, req_data, channel_busy,
    output req_ready, serial_out, grant_id, tx_active
  );

endinterface

// File: rtl/serial_tx_arb_rr_arbiter.sv
// Combinational round-robin pick: first request
// searching upward from ptr+1 with wrap.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_idx
);

  int best_d;
  int d;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    best_d  = NREQ;
    d       = 0;
    for (int i = 0; i < NREQ; i++) begin
      // distance of i behind ptr; 0 means ptr+1
      d = (i + 2*NREQ - int'(ptr) - 1) % NREQ;
      if (req[i] && d < best_d) begin
        best_d  = d;
        gnt     = '0;
        gnt[i]  = 1'b1;
        gnt_idx = IDW'(i);
      end
    end
  end

endmodule

// File: rtl/serial_tx_arb.sv
// Round-robin share of one serial flit channel:
// start bit, FLIT_W data bits LSB first, GUARD idle.
module serial_tx_arb
  import serial_tx_arb_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int FLIT_W = FLIT_W_DEF,
  parameter int GUARD  = 3,
  parameter int IDW    = 2
) (
  input logic           clk,
  input logic           reset,
  serial_tx_arb_if.slave bus
);

  localparam int BCW = (FLIT_W > 1) ? $clog2(FLIT_W) : 1;
  localparam int GCW = (GUARD > 1) ? $clog2(GUARD) : 1;

  tx_state_e         state_q, state_d;
  logic [IDW-1:0]    ptr_q, ptr_d;
  logic [IDW-1:0]    gid_q, gid_d;
  logic [FLIT_W-1:0] sr_q, sr_d;
  logic [BCW-1:0]    bcnt_q, bcnt_d;
  logic [GCW-1:0]    gcnt_q, gcnt_d;

  logic [NREQ-1:0]   gnt;
  logic [IDW-1:0]    gnt_idx;
  logic [FLIT_W-1:0] win_flit;
  logic [NREQ-1:0]   rdy;
  logic              go;
  logic              launch;
  logic              bit_last;
  logic              grd_last;

  rr_arbiter #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    win_flit = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        win_flit = win_flit
                 | bus.req_data[i*FLIT_W +: FLIT_W];
      end
    end
  end

  assign go       = (|bus.req_valid)
                  && !bus.channel_busy;
  assign bit_last = bcnt_q == BCW'(FLIT_W-1);
  assign grd_last = gcnt_q == GCW'(GUARD-1);

  // the edge closing the last guard cycle is
  // also an arbitration edge: back-to-back frames
  assign launch = go
    && (state_q == TX_IDLE
     || (state_q == TX_GUARD && grd_last));

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gid_d   = gid_q;
    sr_d    = sr_q;
    bcnt_d  = bcnt_q;
    gcnt_d  = gcnt_q;
    if (launch) begin
      state_d = TX_START;
      sr_d    = win_flit;
      gid_d   = gnt_idx;
      ptr_d   = gnt_idx;
    end else begin
      unique case (state_q)
        TX_IDLE: ;
        TX_START: begin
          state_d = TX_SHIFT;
          bcnt_d  = '0;
        end
        TX_SHIFT: begin
          sr_d = sr_q >> 1;
          if (bit_last) begin
            state_d = TX_GUARD;
            gcnt_d  = '0;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
        end
        TX_GUARD: begin
          if (grd_last) state_d = TX_IDLE;
          else gcnt_d = gcnt_q + 1'b1;
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      ptr_q   <= IDW'(NREQ-1);
      gid_q   <= '0;
      sr_q    <= '0;
      bcnt_q  <= '0;
      gcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gid_q   <= gid_d;
      sr_q    <= sr_d;
      bcnt_q  <= bcnt_d;
      gcnt_q  <= gcnt_d;
    end
  end

  always_comb begin
    rdy = '0;
    if (state_q == TX_START) rdy[gid_q] = 1'b1;
  end

  assign bus.req_ready  = rdy;
  assign bus.grant_id   = gid_q;
  assign bus.tx_active  = state_q != TX_IDLE;
  assign bus.serial_out = (state_q == TX_START)
    || (state_q == TX_SHIFT && sr_q[0]);

endmodule

// File: tb/tb_serial_tx_arb.sv
// Bench for serial_tx_arb: frame-level model
// checked every cycle, plus directed literals.
module tb_serial_tx_arb;

  localparam int N  = 4;
  localparam int FW = 8;
  localparam int G  = 3;
  localparam int IW = 2;
  localparam int FL = 1 + FW + G;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  serial_tx_arb_if #(
    .NREQ(N), .FLIT_W(FW), .IDW(IW)
  ) bus ();

  serial_tx_arb #(
    .NREQ(N), .FLIT_W(FW), .GUARD(G), .IDW(IW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int pass_n  = 0;
  int total_n = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  // model: cycles left in current frame and its waveform
  int      m_rem = 0;
  int      m_ptr = N-1;
  int      m_gid = 0;
  logic [FW-1:0] m_f;
  logic    m_wave [FL];

  task automatic chk(string nm, logic [31:0] a,
                     logic [31:0] e);
    total_n++;
    if (a === e) pass_n++;
    else $display("FAIL %s: got %0h want %0h",
                  nm, a, e);
  endtask

  function automatic int rr_pick(logic [N-1:0] v,
                                 int p);
    for (int k = 1; k <= N; k++)
      if (v[(p+k)%N]) return (p+k)%N;
    return 0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      m_rem = 0;
      m_ptr = N-1;
      m_gid = 0;
    end else if (m_rem <= 1 && |bus.req_valid
                 && !bus.channel_busy) begin
      m_gid = rr_pick(bus.req_valid, m_ptr);
      m_ptr = m_gid;
      m_f   = bus.req_data[m_gid*FW +: FW];
      for (int i = 0; i < FL; i++)
        m_wave[i] = (i == 0) ? 1'b1
                  : (i <= FW) ? m_f[i-1] : 1'b0;
      m_rem = FL;
    end else if (m_rem > 0) begin
      m_rem--;
    end
  end

  always @(negedge clk) begin
    logic exp_s;
    logic [N-1:0] exp_r;
    if (chk_en) begin
      exp_s = (m_rem > 0) ? m_wave[FL-m_rem] : 1'b0;
      exp_r = (m_rem == FL) ? (N'(1) << m_gid) : '0;
      chk("serial_out", 32'(bus.serial_out),
          32'(exp_s));
      chk("tx_active", 32'(bus.tx_active),
          32'(m_rem > 0));
      chk("req_ready", 32'(bus.req_ready),
          32'(exp_r));
      chk("grant_id", 32'(bus.grant_id),
          32'(m_gid));
    end
  end

  task automatic wait_start(string nm);
    int n = 0;
    @(negedge clk);
    while (bus.req_ready == '0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_timeout"}, 32'(n < 40), 32'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.tx_active && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", 32'(n < 40), 32'd1);
  endtask

  task automatic get_byte(output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b[i] = bus.serial_out;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic set_d(int i, logic [7:0] v);
    bus.req_data[i*FW +: FW] = v;
  endtask

  logic [11:0] seq;
  logic [7:0]  b;
  logic [7:0]  tbl [4];
  int na, last, bad, s3;

  initial begin
    tbl = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.req_valid    = '0;
    bus.req_data     = '0;
    bus.channel_busy = 1'b0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_serial", 32'(bus.serial_out), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_gid", 32'(bus.grant_id), 32'd0);
    chk("rst_txa", 32'(bus.tx_active), 32'd0);
    reset = 1'b1;

    // single request, A5
    set_d(0, 8'hA5);
    bus.req_valid = 4'b0001;
    wait_start("t1");
    chk("t1_gid", 32'(bus.grant_id), 32'd0);
    chk("t1_ready", 32'(bus.req_ready), 32'h1);
    bus.req_valid = '0;
    seq    = '0;
    seq[0] = bus.serial_out;
    na     = int'(bus.tx_active);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i < 12) seq[i] = bus.serial_out;
      na += int'(bus.tx_active);
    end
    chk("t1_seq", 32'(seq), 32'h14B);
    chk("t1_txa_cycles", 32'(na), 32'd12);

    // all four continuously valid
    do_reset();
    for (int i = 0; i < N; i++) set_d(i, tbl[i]);
    bus.req_valid = 4'b1111;
    last = 0;
    for (int f = 0; f < 5; f++) begin
      wait_start("t2");
      chk("t2_gid", 32'(bus.grant_id), 32'(f%4));
      chk("t2_ready", 32'(bus.req_ready),
          32'(1 << (f%4)));
      if (f > 0)
        chk("t2_spacing", 32'(cyc-last), 32'd12);
      last = cyc;
      get_byte(b);
      chk("t2_data", 32'(b), 32'(tbl[f%4]));
    end
    bus.req_valid = '0;
    wait_idle();

    // channel_busy blocks arbitration
    bus.channel_busy = 1'b1;
    set_d(2, 8'h5A);
    bus.req_valid = 4'b0100;
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.req_ready != '0 || bus.serial_out)
        bad++;
    end
    chk("t3_blocked", 32'(bad), 32'd0);
    bus.channel_busy = 1'b0;
    @(negedge clk);
    chk("t3_ready", 32'(bus.req_ready), 32'h4);
    chk("t3_gid", 32'(bus.grant_id), 32'd2);
    chk("t3_start", 32'(bus.serial_out), 32'd1);
    bus.req_valid = '0;
    wait_idle();

    // late requests during a frame for 3
    set_d(3, 8'h0F);
    bus.req_valid = 4'b1000;
    wait_start("t4a");
    chk("t4a_gid3", 32'(bus.grant_id), 32'd3);
    s3 = cyc;
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    set_d(0, 8'h81);
    set_d(1, 8'h18);
    bus.req_valid = 4'b0011;
    wait_start("t4a");
    chk("t4a_gid0", 32'(bus.grant_id), 32'd0);
    chk("t4a_defer", 32'(cyc-s3), 32'd12);
    bus.req_valid[0] = 1'b0;
    wait_start("t4a");
    chk("t4a_gid1", 32'(bus.grant_id), 32'd1);
    bus.req_valid = '0;
    wait_idle();
    bus.req_valid = 4'b1000;
    wait_start("t4b");
    chk("t4b_gid3", 32'(bus.grant_id), 32'd3);
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    bus.req_valid = 4'b0010;
    wait_start("t4b");
    chk("t4b_gid1", 32'(bus.grant_id), 32'd1);
    bus.req_valid = '0;
    wait_idle();

    // reset in the middle of an FF frame
    set_d(0, 8'hFF);
    bus.req_valid = 4'b0001;
    wait_start("t5");
    bus.req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("t5_serial", 32'(bus.serial_out), 32'd0);
    chk("t5_txa", 32'(bus.tx_active), 32'd0);
    chk("t5_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b1;
    bus.req_valid = 4'b1111;
    wait_start("t5");
    chk("t5_gid", 32'(bus.grant_id), 32'd0);
    bus.req_valid = '0;
    wait_idle();

    // data change after the decision edge
    set_d(2, 8'h3C);
    bus.req_valid = 4'b0100;
    wait_start("t6");
    set_d(2, 8'hC3);
    bus.req_valid = '0;
    get_byte(b);
    chk("t6_latched", 32'(b), 32'h3C);
    wait_idle();

    // randomized traffic against the model
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          if ($urandom_range(1, 0) == 0)
            set_d(i, 8'($urandom));
          else
            bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i]
                     && $urandom_range(7, 0) == 0) begin
          set_d(i, 8'($urandom));
          bus.req_valid[i] = 1'b1;
        end
      end
      bus.channel_busy = $urandom_range(3, 0) == 0;
      reset = $urandom_range(499, 0) != 0;
    end
    reset            = 1'b1;
    bus.req_valid    = '0;
    bus.channel_busy = 1'b0;
    @(negedge clk);
    wait_idle();
    @(negedge clk);

    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end

endmodule

// File: doc/serial_tx_arb.md
Name: serial_tx_arb

Overview:
- Shares one serial flit channel between NREQ parallel requesters, round-robin.
- Sits on the transmit side of a link whose far end is a serial-to-parallel flit receiver.
- Serializes the granted flit into the frame format that receiver expects.
- Flow control: starts a new frame only when the receiver reports channel_busy low.

Parameters:
- NREQ, 4, number of requesters (2..8).
- FLIT_W, `HDR_SZ+`PL_SZ+`ADDR_SZ, flit width in bits.
- GUARD, 3, idle cycles after each frame before channel_busy is sampled again. Must cover the receiver's busy-rise latency.
- IDW, 2, width of grant_id; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock.
- reset  input  1  synchronous, active-low.
- req_valid  input  NREQ  per-requester flit-present flag.
- req_data  input  NREQ*FLIT_W  packed flits; requester i occupies bits [i*FLIT_W +: FLIT_W].
- req_ready  output  NREQ  one-hot, one-cycle accept pulse.
- channel_busy  input  1  receiver is holding a flit or receiving one.
- serial_out  output  1  serial line to the receiver.
- grant_id  output  IDW  index of the requester currently being sent.
- tx_active  output  1  high from the START cycle through the last GUARD cycle.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; serial_out=0, req_ready=0, grant_id=0, tx_active=0.
  - Shift register cleared; RR pointer=NREQ-1, so requester 0 has first priority.
  - Reset mid-frame truncates the frame at the next edge (serial_out=0). Recovering the receiver relies on the shared system reset.
- States: IDLE, START, SHIFT, GUARD.
- IDLE:
  - serial_out=0.
  - At an edge with any req_valid high and channel_busy==0:
    - Winner = first valid index searching upward from ptr+1, with wrap.
    - Latch req_data of the winner into the shift register.
    - grant_id<=winner, ptr<=winner, go to START.
  - channel_busy==1 blocks arbitration regardless of requests.
- START:
  - serial_out=1 (start bit); req_ready[grant_id]=1 for this cycle only.
  - Go to SHIFT, bit counter=0.
- SHIFT, FLIT_W cycles:
  - serial_out = flit bit[counter], LSB first; the shift register shifts right each edge.
  - After bit FLIT_W-1, go to GUARD with guard counter=0.
- GUARD, GUARD cycles:
  - serial_out=0; then go to IDLE.
- Frame timing:
  - Decision edge k: START occupies cycle k..k+1, data occupies cycles k+1..k+FLIT_W, GUARD follows.
  - Minimum start-to-start spacing is 1+FLIT_W+GUARD cycles, plus the time channel_busy stays high.
- Handshake:
  - A requester holds req_valid and req_data stable until it sees req_ready; req_ready is asserted only in START.
  - Data is captured at the decision edge, so changes after that edge do not affect the frame in flight.
  - A requester drops req_valid in the cycle after req_ready unless it has another flit; a held req_valid is treated as a new request.
  - Dropping req_valid before req_ready is a protocol violation; the frame still completes with the latched data.
- Fairness:
  - With all NREQ requesters continuously valid, grants cycle 0,1,..,NREQ-1,0.
  - Each requester waits at most NREQ-1 frames.
- Simultaneous events:
  - New requests arriving during START/SHIFT/GUARD are ignored until IDLE.
  - channel_busy changes outside IDLE are ignored.
- grant_id holds its last value while in IDLE.
- tx_active is combinational from state (state!=IDLE). All other outputs are registered or decoded from state only; no combinational path from req_valid to req_ready.

Decomposition:
- Shared constants include (constants.v):
  - Flit width macros (already present).
  - New state encodings TX_IDLE, TX_START, TX_SHIFT, TX_GUARD.
- One sub-module, rr_arbiter (NREQ):
  - Inputs req, ptr; outputs one-hot gnt and gnt_idx; combinational.
  - The FSM, shift register and counters stay in serial_tx_arb.

Test Plan (bench overrides FLIT_W=8, GUARD=3, NREQ=4):
- Reset then single request: req_valid=0001, req_data[7:0]=8'hA5, busy=0.
  - grant_id=0 and req_ready=0001 in the START cycle.
  - serial_out sequence 1,1,0,1,0,0,1,0,1, then 0 for 3 cycles; tx_active high for 12 cycles.
- All four valid continuously with distinct data 8'h11/22/33/44, busy=0.
  - Grant order 0,1,2,3,0; frame starts exactly 12 cycles apart; each frame carries its own data.
- busy=1 held 20 cycles while req_valid=0100:
  - serial_out stays 0, no req_ready.
  - busy falls at cycle t: START begins the cycle after edge t; grant_id=2.
- Request 1 raised during an active frame for requester 3:
  - Ignored until IDLE; next grant is 0 if valid (ptr=3 wraps), otherwise 1.
- reset=0 asserted in the middle of the SHIFT of flit 8'hFF:
  - Next cycle serial_out=0, tx_active=0, req_ready=0000.
  - First grant after reset goes to requester 0 when all are valid.
- req_data changed right after the decision edge: transmitted bits match the value latched at the decision edge.
